ysyx_24100029_hazard_ctrl: RTL and testbench
============================================

YSYX_24100029_HAZARD_CTRL -- requirements
Module: ysyx_24100029_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NFWD, default 2, range 1..4, meaning number of forwarding source stages; index 0 is the youngest (EXU).
REQ-003 SHALL have parameter NREG, default 32 (16 for RV32E), meaning architectural register count; RW = clog2(NREG).
REQ-004 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IDU holds a valid instruction.
- id_rs1 / id_rs2  in  RW  IDU source indices.
- id_rs1_value / id_rs2_value  in  XLEN  register-file read data.
- fwd_valid / fwd_wen / fwd_pending  in  NFWD  per stage: valid, writes rd, result not yet available (load in flight).
- fwd_rd  in  NFWD*RW  per-stage destination.
- fwd_value  in  NFWD*XLEN  per-stage result.
- ex_redirect  in  1  EXU mispredict (valid-qualified upstream).
- ex_target  in  XLEN  EXU corrected PC.
- id_redirect  in  1  IDU jal mispredict.
- id_target  in  XLEN  IDU jal target.
- fence_i  in  1  EXU holds fence.i.
- ex_pc  in  XLEN  EXU PC.
- lsu_idle  in  1  no outstanding memory transaction.
- icache_done  in  1  icache invalidation complete.
- rs1_fwd / rs2_fwd  out  XLEN  resolved operands to EXU.
- stall  out  1  hold IFU/IDU, bubble EXU.
- id_flush / ex_flush  out  1  kill IDU / EXU register contents.
- redirect_valid  out  1  PC override.
- redirect_pc  out  XLEN  override target.
- icache_clr  out  1  one-cycle icache invalidate pulse.
- stall_cnt / flush_cnt  out  32  saturating performance counters.

Function
REQ-005 Forwarding SHALL select, per source, the lowest-index stage with fwd_valid & fwd_wen & fwd_rd==rs & rs!=0; with no match, the register-file value.
REQ-006 Source index 0 SHALL always resolve to the register-file value, never a forward and never a stall.
REQ-007 stall SHALL assert combinationally when id_valid and the selected stage for rs1 or rs2 has fwd_pending=1; older matching stages SHALL NOT override a pending younger one.
REQ-008 In IDLE, ex_redirect SHALL assert redirect_valid, redirect_pc=ex_target, id_flush=1, ex_flush=1 in the same cycle, with priority over id_redirect.
REQ-009 In IDLE without ex_redirect, id_redirect & ~stall SHALL assert redirect_valid, redirect_pc=id_target, id_flush=1; ex_flush=0.
REQ-010 ex_flush SHALL also assert whenever stall=1 (bubble insertion).
REQ-011 FSM states IDLE, DRAIN, CLR, WAIT, REDIR; IDLE->DRAIN when fence_i & ~ex_redirect, latching ex_pc+4 into a target register.
REQ-012 DRAIN: stall=1, id_flush=1; ->CLR when lsu_idle.
REQ-013 CLR: icache_clr=1 for exactly one cycle; ->WAIT.
REQ-014 WAIT: stall=1; ->REDIR when icache_done (same-cycle done in CLR SHALL be accepted).
REQ-015 REDIR: redirect_valid=1, redirect_pc=latched target, id_flush=1, ex_flush=1 for one cycle; ->IDLE.
REQ-016 Outside IDLE, ex_redirect and id_redirect SHALL be ignored.
REQ-017 stall_cnt SHALL increment each cycle stall=1; flush_cnt SHALL increment each cycle redirect_valid=1; both saturate at 0xFFFF_FFFF.
REQ-018 ex_pc+4 SHALL wrap modulo 2^XLEN.

Reset
REQ-019 rst SHALL force IDLE, target register 0, counters 0; outputs stall, flushes, redirect_valid, icache_clr SHALL be 0 in the cycle after rst, including mid-fence.

Structure
REQ-020 FSM state enum and NFWD/NREG limits SHALL live in package ysyx_24100029_ctrl_pkg.
REQ-021 Per-source forward selection SHALL be one sub-module ysyx_24100029_fwd_sel, instantiated twice.

Verification
REQ-022 NFWD=2: rs1=5, stage0 rd=5 value 0x11, stage1 rd=5 value 0x22 -> rs1_fwd=0x11, stall=0.
REQ-023 rs2=7, stage0 rd=7 pending=1, stage1 rd=7 -> stall=1, ex_flush=1, stall_cnt +1.
REQ-024 ex_redirect target 0x8000_0100 and id_redirect together -> redirect_pc=0x8000_0100, both flushes=1, flush_cnt +1.
REQ-025 fence_i at ex_pc=0x8000_0010, lsu_idle low 3 cycles, icache_done 2 cycles after clr -> single icache_clr pulse, then redirect_pc=0x8000_0014.
REQ-026 rst asserted in WAIT -> next cycle IDLE, all control outputs 0, counters 0.
REQ-027 rs1=0 with stage0 rd=0 wen=1 value 0xFFFF_FFFF -> rs1_fwd = id_rs1_value, stall=0.

Source files
------------

// File: rtl/ysyx_24100029_ctrl_pkg.sv
// Shared definitions for the ysyx_24100029 hazard / flush controller:
// fence.i sequencer states, parameter limits and a saturating increment.
package ysyx_24100029_ctrl_pkg;

   localparam int unsigned NfwdMin = 1;
   localparam int unsigned NfwdMax = 4;
   localparam int unsigned NregMin = 16;
   localparam int unsigned NregMax = 32;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StClr,
      StWait,
      StRedir
   } ctrl_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ysyx_24100029_fwd_sel.sv
// Operand bypass for one source register: youngest matching producer wins,
// and its pending flag is reported so the caller can stall on a load-use.
module ysyx_24100029_fwd_sel #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 2,
   parameter int unsigned RW   = 5
) (
   input  logic [RW-1:0]        rs,
   input  logic [XLEN-1:0]      rf_value,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD-1:0]      fwd_wen,
   input  logic [NFWD-1:0]      fwd_pending,
   input  logic [NFWD*RW-1:0]   fwd_rd,
   input  logic [NFWD*XLEN-1:0] fwd_value,
   output logic [XLEN-1:0]      operand,
   output logic                 pending
);

   logic found;

   // Scan from the youngest stage; the first hit blocks all older ones,
   // including when that hit is still pending.
   always_comb begin
      operand = rf_value;
      pending = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < NFWD; i++) begin
         if (!found && rs != '0 && fwd_valid[i] && fwd_wen[i] &&
             fwd_rd[i*RW +: RW] == rs) begin
            found   = 1'b1;
            operand = fwd_value[i*XLEN +: XLEN];
            pending = fwd_pending[i];
         end
      end
   end

endmodule

// File: rtl/ysyx_24100029_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, redirect
// arbitration and the fence.i drain / icache-invalidate / refetch sequence.
module ysyx_24100029_hazard_ctrl
   import ysyx_24100029_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 2,
   parameter int unsigned NREG = 32,
   localparam int unsigned RW  = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [RW-1:0]        id_rs1,
   input  logic [RW-1:0]        id_rs2,
   input  logic [XLEN-1:0]      id_rs1_value,
   input  logic [XLEN-1:0]      id_rs2_value,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD-1:0]      fwd_wen,
   input  logic [NFWD-1:0]      fwd_pending,
   input  logic [NFWD*RW-1:0]   fwd_rd,
   input  logic [NFWD*XLEN-1:0] fwd_value,
   input  logic                 ex_redirect,
   input  logic [XLEN-1:0]      ex_target,
   input  logic                 id_redirect,
   input  logic [XLEN-1:0]      id_target,
   input  logic                 fence_i,
   input  logic [XLEN-1:0]      ex_pc,
   input  logic                 lsu_idle,
   input  logic                 icache_done,
   output logic [XLEN-1:0]      rs1_fwd,
   output logic [XLEN-1:0]      rs2_fwd,
   output logic                 stall,
   output logic                 id_flush,
   output logic                 ex_flush,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 icache_clr,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          flush_cnt
);

   if (NFWD < NfwdMin || NFWD > NfwdMax) begin : g_bad_nfwd
      $error("NFWD out of range");
   end
   if (NREG < NregMin || NREG > NregMax) begin : g_bad_nreg
      $error("NREG out of range");
   end

   logic rs1_pending, rs2_pending;

   ysyx_24100029_fwd_sel #(
      .XLEN (XLEN),
      .NFWD (NFWD),
      .RW   (RW)
   ) u_fwd_rs1 (
      .rs          (id_rs1),
      .rf_value    (id_rs1_value),
      .fwd_valid   (fwd_valid),
      .fwd_wen     (fwd_wen),
      .fwd_pending (fwd_pending),
      .fwd_rd      (fwd_rd),
      .fwd_value   (fwd_value),
      .operand     (rs1_fwd),
      .pending     (rs1_pending)
   );

   ysyx_24100029_fwd_sel #(
      .XLEN (XLEN),
      .NFWD (NFWD),
      .RW   (RW)
   ) u_fwd_rs2 (
      .rs          (id_rs2),
      .rf_value    (id_rs2_value),
      .fwd_valid   (fwd_valid),
      .fwd_wen     (fwd_wen),
      .fwd_pending (fwd_pending),
      .fwd_rd      (fwd_rd),
      .fwd_value   (fwd_value),
      .operand     (rs2_fwd),
      .pending     (rs2_pending)
   );

   ctrl_state_e     state_q;
   logic [XLEN-1:0] target_q;
   logic            done_q;
   logic            hold_q, drain_q, clr_q, redir_q;
   logic [31:0]     stall_cnt_q, flush_cnt_q;

   // Output flags are registered alongside the state and describe the state
   // being entered, so every FSM-driven output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         target_q <= '0;
         done_q   <= 1'b0;
         hold_q   <= 1'b0;
         drain_q  <= 1'b0;
         clr_q    <= 1'b0;
         redir_q  <= 1'b0;
      end else begin
         hold_q  <= 1'b0;
         drain_q <= 1'b0;
         clr_q   <= 1'b0;
         redir_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (fence_i && !ex_redirect) begin
                  state_q  <= StDrain;
                  target_q <= ex_pc + XLEN'(4);
                  hold_q   <= 1'b1;
                  drain_q  <= 1'b1;
               end
            end
            StDrain: begin
               hold_q <= 1'b1;
               if (lsu_idle) begin
                  state_q <= StClr;
                  clr_q   <= 1'b1;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            StClr: begin
               // An invalidate that completes immediately is remembered here.
               state_q <= StWait;
               hold_q  <= 1'b1;
               done_q  <= icache_done;
            end
            StWait: begin
               if (icache_done || done_q) begin
                  state_q <= StRedir;
                  redir_q <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  hold_q <= 1'b1;
               end
            end
            StRedir: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   logic idle, ex_take, id_take;

   always_comb begin
      idle           = (state_q == StIdle);
      stall          = (id_valid && (rs1_pending || rs2_pending)) || hold_q;
      ex_take        = idle && ex_redirect;
      id_take        = idle && !ex_redirect && id_redirect && !stall;
      redirect_valid = ex_take || id_take || redir_q;
      redirect_pc    = redir_q ? target_q : (ex_take ? ex_target : id_target);
      id_flush       = ex_take || id_take || drain_q || redir_q;
      ex_flush       = ex_take || stall || redir_q;
      icache_clr     = clr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall)          stall_cnt_q <= sat_inc(stall_cnt_q);
         if (redirect_valid) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_24100029_hazard_ctrl.sv
// Directed bench for ysyx_24100029_hazard_ctrl: forwarding, load-use stall,
// redirect priority, fence.i sequence and reset during the sequence.
module tb_ysyx_24100029_hazard_ctrl;

   localparam int XLEN = 32;
   localparam int NFWD = 2;
   localparam int RW   = 5;

   logic                 clk, rst;
   logic                 id_valid;
   logic [RW-1:0]        id_rs1, id_rs2;
   logic [XLEN-1:0]      id_rs1_value, id_rs2_value;
   logic [NFWD-1:0]      fwd_valid, fwd_wen, fwd_pending;
   logic [NFWD*RW-1:0]   fwd_rd;
   logic [NFWD*XLEN-1:0] fwd_value;
   logic                 ex_redirect, id_redirect, fence_i, lsu_idle, icache_done;
   logic [XLEN-1:0]      ex_target, id_target, ex_pc;
   logic [XLEN-1:0]      rs1_fwd, rs2_fwd, redirect_pc;
   logic                 stall, id_flush, ex_flush, redirect_valid, icache_clr;
   logic [31:0]          stall_cnt, flush_cnt;
   logic [4:0]           ctl;

   int n_total = 0;
   int n_bad   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   assign ctl = {stall, id_flush, ex_flush, redirect_valid, icache_clr};

   ysyx_24100029_hazard_ctrl #(
      .XLEN (XLEN),
      .NFWD (NFWD),
      .NREG (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rs1_value   (id_rs1_value),
      .id_rs2_value   (id_rs2_value),
      .fwd_valid      (fwd_valid),
      .fwd_wen        (fwd_wen),
      .fwd_pending    (fwd_pending),
      .fwd_rd         (fwd_rd),
      .fwd_value      (fwd_value),
      .ex_redirect    (ex_redirect),
      .ex_target      (ex_target),
      .id_redirect    (id_redirect),
      .id_target      (id_target),
      .fence_i        (fence_i),
      .ex_pc          (ex_pc),
      .lsu_idle       (lsu_idle),
      .icache_done    (icache_done),
      .rs1_fwd        (rs1_fwd),
      .rs2_fwd        (rs2_fwd),
      .stall          (stall),
      .id_flush       (id_flush),
      .ex_flush       (ex_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .icache_clr     (icache_clr),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "timeout");
   end

   task automatic clear_inputs();
      id_valid = 0; id_rs1 = '0; id_rs2 = '0;
      id_rs1_value = '0; id_rs2_value = '0;
      fwd_valid = '0; fwd_wen = '0; fwd_pending = '0; fwd_rd = '0; fwd_value = '0;
      ex_redirect = 0; ex_target = '0; id_redirect = 0; id_target = '0;
      fence_i = 0; ex_pc = '0; lsu_idle = 1; icache_done = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 0;
      #1;
      n_total++;
      if (ctl !== 5'b00000) begin
         n_bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 5'b00000);
      end
      n_total++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_fwd_priority();
      @(negedge clk);
      id_valid = 1; id_rs1 = 5'd5; id_rs2 = 5'd9;
      id_rs1_value = 32'hAAAA_0001; id_rs2_value = 32'hBBBB_0002;
      fwd_valid = 2'b11; fwd_wen = 2'b11; fwd_pending = 2'b00;
      fwd_rd = {5'd5, 5'd5}; fwd_value = {32'h22, 32'h11};
      #1;
      n_total++;
      if (rs1_fwd !== 32'h11 || rs2_fwd !== 32'hBBBB_0002 || stall !== 1'b0) begin
         n_bad++;
         $display("FAIL fwd_young got=%h/%h/%b want=11/bbbb0002/0", rs1_fwd, rs2_fwd, stall);
      end
      @(negedge clk);
      fwd_valid = 2'b10;
      #1;
      n_total++;
      if (rs1_fwd !== 32'h22) begin
         n_bad++; $display("FAIL fwd_old got=%h want=22", rs1_fwd);
      end
      @(negedge clk);
      fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd9};
      #1;
      n_total++;
      if (rs1_fwd !== 32'h22 || rs2_fwd !== 32'h11) begin
         n_bad++; $display("FAIL fwd_split got=%h/%h want=22/11", rs1_fwd, rs2_fwd);
      end
      @(negedge clk);
      fwd_wen = 2'b00;
      #1;
      n_total++;
      if (rs1_fwd !== 32'hAAAA_0001 || rs2_fwd !== 32'hBBBB_0002) begin
         n_bad++;
         $display("FAIL fwd_nowen got=%h/%h want=aaaa0001/bbbb0002", rs1_fwd, rs2_fwd);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_rs_zero();
      @(negedge clk);
      id_valid = 1; id_rs1 = 5'd0; id_rs1_value = 32'h0000_1234;
      fwd_valid = 2'b01; fwd_wen = 2'b01; fwd_pending = 2'b01;
      fwd_rd = {5'd3, 5'd0}; fwd_value = {32'h0, 32'hFFFF_FFFF};
      #1;
      n_total++;
      if (rs1_fwd !== 32'h0000_1234 || stall !== 1'b0) begin
         n_bad++; $display("FAIL rs_zero got=%h/%b want=00001234/0", rs1_fwd, stall);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_load_stall();
      @(negedge clk);
      id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd7;
      fwd_valid = 2'b11; fwd_wen = 2'b11; fwd_pending = 2'b01;
      fwd_rd = {5'd7, 5'd7}; fwd_value = {32'h44, 32'h33};
      id_redirect = 1; id_target = 32'h8000_0800;
      #1;
      n_total++;
      if (ctl !== 5'b10100) begin
         n_bad++; $display("FAIL load_stall_ctl got=%b want=%b", ctl, 5'b10100);
      end
      exp_stall++;
      @(negedge clk);
      id_valid = 0; id_redirect = 0;
      #1;
      n_total++;
      if (stall !== 1'b0 || stall_cnt !== 32'(exp_stall)) begin
         n_bad++; $display("FAIL stall_invalid got=%b/%0d want=0/%0d", stall, stall_cnt, exp_stall);
      end
      @(negedge clk);
      id_valid = 1; fwd_pending = 2'b10;
      #1;
      n_total++;
      if (stall !== 1'b0 || rs2_fwd !== 32'h33) begin
         n_bad++; $display("FAIL stall_old_pending got=%b/%h want=0/33", stall, rs2_fwd);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      n_total++;
      if (flush_cnt !== 32'(exp_flush)) begin
         n_bad++; $display("FAIL stall_no_flush got=%0d want=%0d", flush_cnt, exp_flush);
      end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      ex_redirect = 1; ex_target = 32'h8000_0100;
      id_redirect = 1; id_target = 32'h8000_0200;
      #1;
      n_total++;
      if (ctl !== 5'b01110 || redirect_pc !== 32'h8000_0100) begin
         n_bad++; $display("FAIL ex_redir got=%b/%h want=01110/80000100", ctl, redirect_pc);
      end
      exp_flush++;
      @(negedge clk);
      ex_redirect = 0;
      #1;
      n_total++;
      if (ctl !== 5'b01010 || redirect_pc !== 32'h8000_0200 || flush_cnt !== 32'(exp_flush)) begin
         n_bad++;
         $display("FAIL id_redir got=%b/%h/%0d want=01010/80000200/%0d",
                  ctl, redirect_pc, flush_cnt, exp_flush);
      end
      exp_flush++;
      @(negedge clk);
      id_redirect = 0; ex_redirect = 1; ex_target = 32'h8000_0300; fence_i = 1;
      #1;
      n_total++;
      if (ctl !== 5'b01110 || redirect_pc !== 32'h8000_0300) begin
         n_bad++; $display("FAIL ex_over_fence got=%b/%h want=01110/80000300", ctl, redirect_pc);
      end
      exp_flush++;
      @(negedge clk);
      clear_inputs();
      #1;
      n_total++;
      if (ctl !== 5'b00000 || flush_cnt !== 32'(exp_flush)) begin
         n_bad++;
         $display("FAIL fence_suppressed got=%b/%0d want=00000/%0d", ctl, flush_cnt, exp_flush);
      end
   endtask

   task automatic test_fence();
      int clr_seen = 0;
      @(negedge clk);
      fence_i = 1; ex_pc = 32'h8000_0010; lsu_idle = 0;
      #1;
      n_total++;
      if (ctl !== 5'b00000) begin
         n_bad++; $display("FAIL fence_accept got=%b want=%b", ctl, 5'b00000);
      end
      @(negedge clk);
      fence_i = 0; ex_redirect = 1; ex_target = 32'h1234_5678;
      id_redirect = 1; id_target = 32'h2345_6780;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) lsu_idle = 1;
         #1;
         clr_seen += int'(icache_clr);
         n_total++;
         if (ctl !== 5'b11100) begin
            n_bad++; $display("FAIL drain_%0d got=%b want=%b", k, ctl, 5'b11100);
         end
         @(negedge clk);
      end
      lsu_idle = 0;
      #1;
      clr_seen += int'(icache_clr);
      n_total++;
      if (ctl !== 5'b10101) begin
         n_bad++; $display("FAIL clr got=%b want=%b", ctl, 5'b10101);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (k == 1) icache_done = 1;
         #1;
         clr_seen += int'(icache_clr);
         n_total++;
         if (ctl !== 5'b10100) begin
            n_bad++; $display("FAIL wait_%0d got=%b want=%b", k, ctl, 5'b10100);
         end
      end
      @(negedge clk);
      icache_done = 0;
      #1;
      clr_seen += int'(icache_clr);
      n_total++;
      if (ctl !== 5'b01110 || redirect_pc !== 32'h8000_0014) begin
         n_bad++; $display("FAIL fence_redir got=%b/%h want=01110/80000014", ctl, redirect_pc);
      end
      exp_stall += 7;
      exp_flush++;
      @(negedge clk);
      clear_inputs();
      #1;
      n_total++;
      if (ctl !== 5'b00000 || clr_seen != 1) begin
         n_bad++; $display("FAIL fence_end got=%b/%0d want=00000/1", ctl, clr_seen);
      end
      n_total++;
      if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
         n_bad++;
         $display("FAIL fence_cnt got=%0d/%0d want=%0d/%0d",
                  stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_fence_fast_wrap();
      @(negedge clk);
      fence_i = 1; ex_pc = 32'hFFFF_FFFC; lsu_idle = 1;
      @(negedge clk);
      fence_i = 0;
      @(negedge clk);
      icache_done = 1;
      #1;
      n_total++;
      if (ctl !== 5'b10101) begin
         n_bad++; $display("FAIL fast_clr got=%b want=%b", ctl, 5'b10101);
      end
      @(negedge clk);
      icache_done = 0;
      #1;
      n_total++;
      if (ctl !== 5'b10100) begin
         n_bad++; $display("FAIL fast_wait got=%b want=%b", ctl, 5'b10100);
      end
      @(negedge clk);
      #1;
      n_total++;
      if (ctl !== 5'b01110 || redirect_pc !== 32'h0000_0000) begin
         n_bad++; $display("FAIL wrap_redir got=%b/%h want=01110/00000000", ctl, redirect_pc);
      end
      exp_stall += 3;
      exp_flush++;
      @(negedge clk);
      #1;
      n_total++;
      if (ctl !== 5'b00000 || stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
         n_bad++;
         $display("FAIL fast_end got=%b/%0d/%0d want=00000/%0d/%0d",
                  ctl, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_reset_mid_fence();
      @(negedge clk);
      fence_i = 1; ex_pc = 32'h8000_0040; lsu_idle = 1;
      @(negedge clk);
      fence_i = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      n_total++;
      if (ctl !== 5'b10100) begin
         n_bad++; $display("FAIL pre_reset_wait got=%b want=%b", ctl, 5'b10100);
      end
      @(negedge clk);
      rst = 0; icache_done = 1;
      exp_stall = 0;
      exp_flush = 0;
      #1;
      n_total++;
      if (ctl !== 5'b00000 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL mid_reset got=%b/%0d/%0d want=00000/0/0", ctl, stall_cnt, flush_cnt);
      end
      @(negedge clk);
      icache_done = 0;
      #1;
      n_total++;
      if (ctl !== 5'b00000) begin
         n_bad++; $display("FAIL post_reset_idle got=%b want=%b", ctl, 5'b00000);
      end
   endtask

   initial begin
      test_reset();
      test_fwd_priority();
      test_rs_zero();
      test_load_stall();
      test_redirect();
      test_fence();
      test_fence_fast_wrap();
      test_reset_mid_fence();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
